ai_paddle_ctl: RTL and testbench

Computer opponent for the pong player channel. Generates the ply_up / ply_down move requests that the paddle position controller consumes. Tracks the ball while it approaches and recentres while it moves away. The paddle position is fed back from the position controller. Requests are one-cycle strobes, one per video frame, so the paddle moves `speed` pixels per frame.

---
 rtl/pong_pkg.sv | 32 +++
 rtl/lfsr8.sv | 24 ++
 rtl/ai_paddle_ctl.sv | 114 +++++++++++
 tb/tb_ai_paddle_ctl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared pong definitions: screen geometry defaults, AI opponent state encoding,
// derived clamp limits and miss-generator constants.
package pong_pkg;

  localparam int SCREEN_HEIGHT_DEF = 600;
  localparam int PADDLE_HEIGHT_DEF = 100;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    CENTER = 2'd1,
    TRACK  = 2'd2
  } ai_state_t;

  // Paddle centre may never leave the screen, so targets are kept half a paddle in.
  localparam int CLAMP_LO = PADDLE_HEIGHT_DEF / 2;
  localparam int CLAMP_HI = SCREEN_HEIGHT_DEF - PADDLE_HEIGHT_DEF / 2;

  localparam int         MISS_OFFSET = 64;
  localparam logic [7:0] LFSR_SEED   = 8'hA5;

  function automatic logic [10:0] clamp_y(input logic [10:0] y,
                                          input logic [10:0] lo,
                                          input logic [10:0] hi);
    if (y < lo)
      return lo;
    else if (y > hi)
      return hi;
    else
      return y;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Step-enabled 8-bit Fibonacci LFSR (taps 8,6,5,4) with synchronous reset to seed.
module lfsr8
  import pong_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [7:0] value
);

  logic feedback;

  assign feedback = value[7] ^ value[5] ^ value[4] ^ value[3];

  always_ff @(posedge clk) begin
    if (rst)
      value <= SEED;
    else if (step)
      value <= {value[6:0], feedback};
  end

endmodule

// File: rtl/ai_paddle_ctl.sv
// Computer opponent: emits one-frame up/down move strobes that steer the paddle
// toward a periodically re-latched target. Optional AI_MISS_EN adds random misses.
module ai_paddle_ctl
  import pong_pkg::*;
#(
  parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter int PADDLE_HEIGHT = PADDLE_HEIGHT_DEF,
  parameter int DEAD_ZONE     = 8,
  parameter int REACT_FRAMES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic [9:0] ball_y,
  input  logic       ball_dir,
  input  logic [9:0] pos_ply,
  output logic       ply_up,
  output logic       ply_down,
  output logic [1:0] ai_state
);

  localparam logic [10:0] LO   = 11'(PADDLE_HEIGHT / 2);
  localparam logic [10:0] HI   = 11'(SCREEN_HEIGHT - PADDLE_HEIGHT / 2);
  localparam logic [10:0] MID  = 11'(SCREEN_HEIGHT / 2);
  localparam logic [10:0] HALF = 11'(PADDLE_HEIGHT / 2);
  localparam logic [10:0] DZ   = 11'(DEAD_ZONE);
  localparam int          CW   = $clog2(REACT_FRAMES + 1);
  localparam logic [CW-1:0] LAST = CW'(REACT_FRAMES - 1);

  ai_state_t   state, next_state;
  logic [CW-1:0] react_cnt;
  logic [10:0] target;
  logic [10:0] ball_c, track_target, new_target, centre;
  logic        state_change, count_tick, latch, decide, want_up, want_down;

  always_comb begin
    next_state = state;
    if (!enable)
      next_state = OFF;
    else if (ball_dir)
      next_state = TRACK;
    else
      next_state = CENTER;
  end

  assign state_change = (next_state != state);
  assign count_tick   = frame_tick && (state != OFF) && !state_change;
  assign latch        = count_tick && (react_cnt == LAST);
  assign decide       = frame_tick && (state != OFF) && (next_state != OFF);

  assign ball_c = clamp_y({1'b0, ball_y}, LO, HI);

`ifdef AI_MISS_EN
  logic [7:0] lfsr;
  logic       miss;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (latch),
    .value (lfsr)
  );

  assign miss         = ((lfsr & 8'h07) == 8'h00);
  assign track_target = miss ? clamp_y(ball_c + 11'(MISS_OFFSET), LO, HI) : ball_c;
`else
  assign track_target = ball_c;
`endif

  assign new_target = (state == TRACK) ? track_target : MID;

  // Decisions compare against the target held before any same-cycle latch.
  assign centre    = {1'b0, pos_ply} + HALF;
  assign want_down = target > (centre + DZ);
  assign want_up   = centre > (target + DZ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      react_cnt <= '0;
      target    <= MID;
    end else if (state_change) begin
      react_cnt <= '0;
    end else if (count_tick) begin
      if (latch) begin
        react_cnt <= '0;
        target    <= new_target;
      end else begin
        react_cnt <= react_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ply_up   <= 1'b0;
      ply_down <= 1'b0;
    end else begin
      ply_up   <= decide && want_up;
      ply_down <= decide && want_down;
    end
  end

  assign ai_state = state;

endmodule

// File: tb/tb_ai_paddle_ctl.sv
// Directed self-checking bench for ai_paddle_ctl at default parameters;
// the AI_MISS_EN build checks latched targets against a reference LFSR model.
module tb_ai_paddle_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       frame_tick;
  logic [9:0] ball_y;
  logic       ball_dir;
  logic [9:0] pos_ply;
  logic       ply_up;
  logic       ply_down;
  logic [1:0] ai_state;

  int         tests = 0;
  int         fails = 0;
  logic [1:0] exp_state;

  ai_paddle_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .frame_tick (frame_tick),
    .ball_y     (ball_y),
    .ball_dir   (ball_dir),
    .pos_ply    (pos_ply),
    .ply_up     (ply_up),
    .ply_down   (ply_down),
    .ai_state   (ai_state)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic tick);
    @(negedge clk);
    frame_tick = tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic eu, input logic ed, input logic [1:0] es);
    checkVal({tag, "_up"}, 11'(ply_up), 11'(eu));
    checkVal({tag, "_down"}, 11'(ply_down), 11'(ed));
    checkVal({tag, "_state"}, 11'(ai_state), 11'(es));
  endtask

  task automatic tickCheck(input string tag, input logic eu, input logic ed);
    applyStimulus(1'b1);
    checkOutput(tag, eu, ed, exp_state);
    applyStimulus(1'b0);
    checkOutput({tag, "_idle"}, 1'b0, 1'b0, exp_state);
  endtask

`ifdef AI_MISS_EN
  function automatic logic [7:0] lfsrNext(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction
`endif

  initial begin
    rst        = 1'b1;
    enable     = 1'b1;
    frame_tick = 1'b0;
    ball_y     = 10'd400;
    ball_dir   = 1'b1;
    pos_ply    = 10'd100;
    exp_state  = 2'd0;

    // Reset held with enable and ticks active
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1);
      checkOutput("reset", 1'b0, 1'b0, 2'd0);
    end
    checkVal("reset_target", dut.target, 11'd300);
    checkVal("reset_cnt", 11'(dut.react_cnt), 11'd0);

    rst       = 1'b0;
    exp_state = 2'd2;
    applyStimulus(1'b0);
    checkOutput("release", 1'b0, 1'b0, 2'd2);

`ifndef AI_MISS_EN
    // Tracking: centre 150 against old target 300, latch 400 on 4th tick
    for (int i = 0; i < 4; i++) tickCheck("track", 1'b0, 1'b1);
    checkVal("latch400", dut.target, 11'd400);
    checkVal("latch_cnt", 11'(dut.react_cnt), 11'd0);

    // Dead zone: centre 300
    pos_ply = 10'd250;
    ball_y  = 10'd305;
    for (int i = 0; i < 4; i++) tickCheck("dz_old400", 1'b0, 1'b1);
    checkVal("latch305", dut.target, 11'd305);
    ball_y = 10'd308;
    for (int i = 0; i < 4; i++) tickCheck("dz_305", 1'b0, 1'b0);
    checkVal("latch308", dut.target, 11'd308);
    ball_y = 10'd309;
    for (int i = 0; i < 4; i++) tickCheck("dz_308", 1'b0, 1'b0);
    checkVal("latch309", dut.target, 11'd309);
    tickCheck("dz_309", 1'b0, 1'b1);
    checkVal("cnt_one", 11'(dut.react_cnt), 11'd1);

    // Recentre: centre 450, old target 309 until the 4th tick latches 300
    ball_dir  = 1'b0;
    pos_ply   = 10'd400;
    exp_state = 2'd1;
    applyStimulus(1'b0);
    checkOutput("recentre", 1'b0, 1'b0, 2'd1);
    checkVal("recentre_cnt", 11'(dut.react_cnt), 11'd0);
    checkVal("recentre_keep", dut.target, 11'd309);
    for (int i = 0; i < 4; i++) tickCheck("ctr_old", 1'b1, 1'b0);
    checkVal("latch300", dut.target, 11'd300);
    tickCheck("ctr_new", 1'b1, 1'b0);
    pos_ply = 10'd258;
    tickCheck("ctr_308", 1'b0, 1'b0);
    pos_ply = 10'd259;
    tickCheck("ctr_309", 1'b1, 1'b0);

    // Clamp: centre 309
    ball_dir  = 1'b1;
    ball_y    = 10'd5;
    exp_state = 2'd2;
    applyStimulus(1'b0);
    checkOutput("to_track", 1'b0, 1'b0, 2'd2);
    checkVal("to_track_cnt", 11'(dut.react_cnt), 11'd0);
    for (int i = 0; i < 4; i++) tickCheck("clamp_lo", 1'b1, 1'b0);
    checkVal("clamp50", dut.target, 11'd50);
    ball_y = 10'd590;
    for (int i = 0; i < 4; i++) tickCheck("clamp_hi", 1'b1, 1'b0);
    checkVal("clamp550", dut.target, 11'd550);

    // Disable in the same cycle as a tick
    tickCheck("pre_off", 1'b0, 1'b1);
    enable    = 1'b0;
    exp_state = 2'd0;
    applyStimulus(1'b1);
    checkOutput("off_tick", 1'b0, 1'b0, 2'd0);
    checkVal("off_cnt", 11'(dut.react_cnt), 11'd0);
    checkVal("off_target", dut.target, 11'd550);
    applyStimulus(1'b1);
    checkOutput("off_hold", 1'b0, 1'b0, 2'd0);

    // Reset discards a pending down decision
    enable    = 1'b1;
    exp_state = 2'd2;
    applyStimulus(1'b0);
    checkOutput("re_enable", 1'b0, 1'b0, 2'd2);
    rst = 1'b1;
    applyStimulus(1'b1);
    checkOutput("rst_pending", 1'b0, 1'b0, 2'd0);
    checkVal("rst_target", dut.target, 11'd300);
    rst = 1'b0;
    applyStimulus(1'b0);
`else
    begin
      logic [7:0]  model;
      logic [10:0] exp_t;
      model   = 8'hA5;
      ball_y  = 10'd200;
      for (int n = 0; n < 16; n++) begin
        for (int k = 0; k < 4; k++) begin
          applyStimulus(1'b1);
          checkVal("excl", 11'(ply_up & ply_down), 11'd0);
          applyStimulus(1'b0);
        end
        exp_t = (model[2:0] == 3'b000) ? 11'd264 : 11'd200;
        model = lfsrNext(model);
        checkVal("miss_target", dut.target, exp_t);
        checkVal("miss_range", 11'((dut.target >= 11'd50) && (dut.target <= 11'd550)), 11'd1);
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
